add4_arbiter: RTL

Shares one four-operand adder datapath among `NREQ` requesters. Each requester presents four `W`-bit operands. A round-robin arbiter grants one requester at a time. The block captures the winner's operands and registers the sum and overflow flag. It returns the result on a valid/ready handshake tagged with the requester id. It sits between client blocks and the single adder instance, so the adder is never instantiated per client.

---
 rtl/add4_pkg.sv | 27 ++
 rtl/add4_core.sv | 14 +
 rtl/add4_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/add4_pkg.sv
// rtl/add4_pkg.sv - shared types, defaults and helpers for the add4 arbiter slice
package add4_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Round-robin pick: first set request after last, wrapping; last itself is lowest priority.
  function automatic int rr_pick(input logic [7:0] req, input int n, input int last);
    int idx;
    rr_pick = last;
    for (int k = n; k >= 1; k--) begin
      idx = (last + k) % n;
      if (req[idx[2:0]]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/add4_core.sv
// rtl/add4_core.sv - combinational four-operand adder with carry-preserving full sum
module add4_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W+1:0] full
);

  assign full = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};

endmodule

// File: rtl/add4_arbiter.sv
// rtl/add4_arbiter.sv - round-robin share of one add4_core among NREQ requesters
module add4_arbiter
  import add4_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*4*W-1:0]       opnd,
  output logic [NREQ-1:0]           gnt,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [W-1:0]              res_sum,
  output logic                      res_ov,
  output logic [id_width(NREQ)-1:0] res_id
);

  localparam int IW = id_width(NREQ);

  state_t         state;
  logic [IW-1:0]  last_id;
  logic [IW-1:0]  cap_id;
  logic [IW-1:0]  win_id;
  logic [4*W-1:0] cap_ops;
  logic [W+1:0]   full;
  logic [7:0]     req_ext;
  int             win;
  logic           issue;

  always_comb begin
    req_ext = '0;
    req_ext[NREQ-1:0] = req;
    win    = rr_pick(req_ext, NREQ, int'(last_id));
    win_id = IW'(win);
  end

  // Arbitration happens only from IDLE or on a HOLD transfer; requests seen elsewhere are ignored.
  assign issue = (|req) && ((state == ST_IDLE) || ((state == ST_HOLD) && res_ready));

  add4_core #(.W(W)) u_core (
    .a    (cap_ops[0*W +: W]),
    .b    (cap_ops[1*W +: W]),
    .c    (cap_ops[2*W +: W]),
    .d    (cap_ops[3*W +: W]),
    .full (full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_ov    <= 1'b0;
      res_id    <= '0;
      last_id   <= IW'(NREQ - 1);
      cap_id    <= '0;
      cap_ops   <= '0;
    end else begin
      gnt <= '0;
      case (state)
        ST_IDLE: ;
        ST_CALC: begin
          res_sum   <= full[W-1:0];
          res_ov    <= |full[W+1:W];
          res_id    <= cap_id;
          res_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (issue) begin
        gnt     <= NREQ'(1) << win_id;
        cap_ops <= opnd[win*4*W +: 4*W];
        cap_id  <= win_id;
        last_id <= win_id;
        state   <= ST_CALC;
      end
    end
  end

endmodule
